// File: rtl/mdu_ctrl.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// One shift-add or restoring shift-subtract step per cycle; 33-cycle latency.
module mdu_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wdata,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        div0
);

  localparam int unsigned W    = 32;
  localparam int unsigned CW   = 6;
  localparam int unsigned ITER = 32;

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            is_div;
  logic            sgn_a;
  logic            sgn_b;
  logic            dz;
  logic [W-1:0]    opnd;
  logic [2*W-1:0]  acc;

  logic            rs_neg;
  logic            rt_neg;
  logic [W-1:0]    rs_mag;
  logic [W-1:0]    rt_mag;
  logic [W:0]      mul_sum;
  logic [2*W-1:0]  mul_next;
  logic [W:0]      div_part;
  logic [W:0]      div_diff;
  logic [2*W-1:0]  div_next;
  logic [2*W-1:0]  prod_fix;
  logic [W-1:0]    quo_fix;
  logic [W-1:0]    rem_fix;

  // Operand magnitudes, one datapath step, and final sign correction
  always_comb begin
    rs_neg   = ~op[0] & rs_val[W-1];
    rt_neg   = ~op[0] & rt_val[W-1];
    rs_mag   = rs_neg ? W'(-rs_val) : rs_val;
    rt_mag   = rt_neg ? W'(-rt_val) : rt_val;

    mul_sum  = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, opnd} : (W+1)'(0));
    mul_next = {mul_sum, acc[W-1:1]};

    div_part = acc[2*W-1:W-1];
    div_diff = div_part - {1'b0, opnd};
    div_next = div_diff[W] ? {div_part[W-1:0], acc[W-2:0], 1'b0}
                           : {div_diff[W-1:0], acc[W-2:0], 1'b1};

    prod_fix = (sgn_a ^ sgn_b) ? (2*W)'(-acc) : acc;
    quo_fix  = (sgn_a ^ sgn_b) ? W'(-acc[W-1:0]) : acc[W-1:0];
    rem_fix  = sgn_a ? W'(-acc[2*W-1:W]) : acc[2*W-1:W];
  end

  // Control FSM with registered outputs and HI/LO architectural state
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      is_div <= 1'b0;
      sgn_a  <= 1'b0;
      sgn_b  <= 1'b0;
      dz     <= 1'b0;
      opnd   <= '0;
      acc    <= '0;
      hi     <= '0;
      lo     <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      div0   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (flush) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (hi_we) hi <= wdata;
            if (lo_we) lo <= wdata;
            if (start) begin
              is_div <= op[1];
              sgn_a  <= rs_neg;
              sgn_b  <= rt_neg;
              dz     <= (rt_val == '0);
              opnd   <= op[1] ? rt_mag : rs_mag;
              acc    <= {{W{1'b0}}, (op[1] ? rs_mag : rt_mag)};
              cnt    <= '0;
              state  <= CALC;
              busy   <= 1'b1;
            end
          end
          CALC: begin
            acc <= is_div ? div_next : mul_next;
            cnt <= cnt + CW'(1);
            if (cnt == CW'(ITER - 1)) state <= FIX;
          end
          FIX: begin
            if (is_div) begin
              // With a zero divisor the remainder ends up as the dividend magnitude
              lo   <= dz ? {W{1'b1}} : quo_fix;
              hi   <= rem_fix;
              div0 <= dz;
            end else begin
              {hi, lo} <= prod_fix;
            end
            done  <= 1'b1;
            state <= IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl: arithmetic results, latency, flush, reset and
// write-port interactions with hand-computed expectations.
module tb_mdu_ctrl;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wdata;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        div0;

  int total = 0;
  int bad   = 0;
  int cyc;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  mdu_ctrl dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .rs_val (rs_val),
    .rt_val (rt_val),
    .hi_we  (hi_we),
    .lo_we  (lo_we),
    .wdata  (wdata),
    .flush  (flush),
    .busy   (busy),
    .done   (done),
    .hi     (hi),
    .lo     (lo),
    .div0   (div0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present an operation for one accepting edge, then scramble operands
  task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    start  = 1'b1;
    op     = o;
    rs_val = a;
    rt_val = b;
    tick();
    start  = 1'b0;
    hi_we  = 1'b0;
    lo_we  = 1'b0;
    rs_val = ~a;
    rt_val = ~b;
  endtask

  // Count cycles until busy drops; optionally inject ignored start/mthi/mtlo
  task automatic wait_done(input bit poke, output int n);
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      if (poke && (n == 5 || n == 20)) begin
        start = 1'b1;
        op    = OP_DIV;
        hi_we = 1'b1;
        lo_we = 1'b1;
        wdata = 32'hDEAD_BEEF;
      end else begin
        start = 1'b0;
        hi_we = 1'b0;
        lo_we = 1'b0;
      end
      tick();
      n++;
    end
    start = 1'b0;
    hi_we = 1'b0;
    lo_we = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo);
    int n;
    launch(o, a, b);
    wait_done(1'b0, n);
    chk({tag, "_lat"}, 32'(n), 32'd33);
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_hi"}, hi, exp_hi);
    chk({tag, "_lo"}, lo, exp_lo);
  endtask

  initial begin
    reset  = 1'b1;
    start  = 1'b0;
    op     = OP_MULT;
    rs_val = '0;
    rt_val = '0;
    hi_we  = 1'b0;
    lo_we  = 1'b0;
    wdata  = '0;
    flush  = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_div0", 32'(div0), 32'd0);

    // Signed multiply, then done must last only one cycle
    run_op("mult_n3x5", OP_MULT, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    tick();
    chk("mult_done_pulse", 32'(done), 32'd0);
    chk("mult_idle", 32'(busy), 32'd0);

    run_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("mult_nn", OP_MULT, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h0, 32'd6);

    run_op("div_n7d2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    chk("div_n7d2_div0", 32'(div0), 32'd0);
    run_op("div_7dn2", OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD);

    // Divide by zero, then a back-to-back divu launched in the done cycle
    run_op("divu_z", OP_DIVU, 32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF);
    chk("divu_z_div0", 32'(div0), 32'd1);
    run_op("divu_100d7", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);
    chk("divu_100d7_div0", 32'(div0), 32'd0);

    run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);
    run_op("div_nz", OP_DIV, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF);
    chk("div_nz_div0", 32'(div0), 32'd1);

    // mthi, then flush a multiply mid-flight
    tick();
    hi_we = 1'b1;
    wdata = 32'h0000_1234;
    tick();
    hi_we = 1'b0;
    chk("mthi", hi, 32'h0000_1234);
    launch(OP_MULT, 32'd3, 32'd4);
    for (int i = 0; i < 9; i++) tick();
    chk("pre_flush_busy", 32'(busy), 32'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_busy", 32'(busy), 32'd0);
    chk("flush_done", 32'(done), 32'd0);
    chk("flush_hi", hi, 32'h0000_1234);
    chk("flush_div0", 32'(div0), 32'd1);
    tick();
    chk("flush_done2", 32'(done), 32'd0);

    // Stray start/mthi/mtlo during a busy operation have no effect
    launch(OP_MULTU, 32'd6, 32'd7);
    wait_done(1'b1, cyc);
    chk("poke_lat", 32'(cyc), 32'd33);
    chk("poke_hi", hi, 32'd0);
    chk("poke_lo", lo, 32'd42);
    tick();
    chk("poke_idle", 32'(busy), 32'd0);

    // mthi/mtlo and start on the same edge: write lands, then result overwrites
    hi_we = 1'b1;
    lo_we = 1'b1;
    wdata = 32'h0000_0055;
    launch(OP_MULT, 32'd2, 32'd3);
    chk("same_edge_hi", hi, 32'h0000_0055);
    chk("same_edge_lo", lo, 32'h0000_0055);
    chk("same_edge_busy", 32'(busy), 32'd1);
    wait_done(1'b0, cyc);
    chk("same_edge_lat", 32'(cyc), 32'd33);
    chk("same_edge_rhi", hi, 32'd0);
    chk("same_edge_rlo", lo, 32'd6);

    // Reset in the middle of a divu, with div0 previously set
    run_op("divu_z2", OP_DIVU, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF);
    chk("divu_z2_div0", 32'(div0), 32'd1);
    launch(OP_DIVU, 32'd1000, 32'd3);
    for (int i = 0; i < 14; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_hi", hi, 32'd0);
    chk("mid_rst_lo", lo, 32'd0);
    chk("mid_rst_div0", 32'(div0), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    for (int i = 0; i < 25; i++) begin
      tick();
      if (done !== 1'b0 || busy !== 1'b0) chk("post_rst_quiet", {30'd0, busy, done}, 32'd0);
    end
    chk("post_rst_lo", lo, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mdu_ctrl.md
MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port start, input, 1 bit: request to begin the operation selected by op; sampled only in IDLE.
REQ-004 SHALL have port op, input, 2 bits: 00 mult, 01 multu, 10 div, 11 divu.
REQ-005 SHALL have port rs_val, input, 32 bits: multiplicand or dividend.
REQ-006 SHALL have port rt_val, input, 32 bits: multiplier or divisor.
REQ-007 SHALL have ports hi_we and lo_we, input, 1 bit each: mthi and mtlo write enables.
REQ-008 SHALL have port wdata, input, 32 bits: mthi and mtlo data.
REQ-009 SHALL have port flush, input, 1 bit: abort the operation in flight.
REQ-010 SHALL have port busy, output, 1 bit: high while not in IDLE; the pipeline stalls MDU-dependent instructions on it.
REQ-011 SHALL have port done, output, 1 bit: one-cycle pulse when HI and LO have been updated by an operation.
REQ-012 SHALL have ports hi and lo, output, 32 bits each: architectural HI and LO registers.
REQ-013 SHALL have port div0, output, 1 bit: registered; set when the last completed div or divu had rt_val equal to 0.

Function
REQ-014 SHALL implement the FSM states IDLE, CALC and FIX; busy SHALL equal (state != IDLE).
REQ-015 IDLE with start=1 and flush=0 at edge E0 SHALL latch op, operand magnitudes (for signed ops), sign flags and divisor-zero flag; load cnt=0; go to CALC.
REQ-016 CALC SHALL perform one iteration per cycle: shift-add for multiply (64-bit product), restoring shift-subtract for divide (32-bit quotient and remainder); cnt increments; after the 32nd iteration (edge E0+32) go to FIX.
REQ-017 FIX SHALL at edge E0+33 apply sign correction, write hi and lo, update div0 (div ops only), pulse done for the following cycle, and return to IDLE.
REQ-018 Total latency from the accepting edge to the HI/LO update SHALL be 33 cycles; busy SHALL be high for exactly 33 cycles; a new start SHALL be accepted in the cycle done is high.
REQ-019 mult and multu results SHALL be hi = product[63:32] and lo = product[31:0]; mult SHALL negate the 64-bit product when the operand signs differ.
REQ-020 div and divu results SHALL be lo = quotient and hi = remainder; signed: quotient negative iff signs differ, remainder takes the dividend's sign.
REQ-021 Divide by zero SHALL give lo=32'hFFFFFFFF and hi=rs_val, skip sign correction and set div0=1; any other completed div or divu SHALL clear div0.
REQ-022 div of 32'h80000000 by 32'hFFFFFFFF SHALL give lo=32'h80000000 and hi=0.
REQ-023 start, hi_we and lo_we SHALL be ignored while busy.
REQ-024 In IDLE, hi_we and lo_we SHALL write wdata at the edge; if start is accepted at the same edge, both the write and the start SHALL take effect, and the later result SHALL overwrite HI and LO.
REQ-025 flush=1 SHALL return the FSM to IDLE at the next edge from any state, leave hi, lo and div0 unchanged, suppress done, and block any start in the same cycle.
REQ-026 Operand ports SHALL be sampled only at the accepting edge; later changes SHALL have no effect.

Reset
REQ-027 reset=1 at an edge SHALL force IDLE, cnt=0, hi=0, lo=0, busy=0, done=0 and div0=0, overriding all other inputs including mid-operation.

Verification
REQ-028 mult: rs=32'hFFFFFFFD (-3), rt=5 -> after 33 cycles, hi=32'hFFFFFFFF, lo=32'hFFFFFFF1, done for 1 cycle, busy high for 33 cycles.
REQ-029 multu: rs=rt=32'hFFFFFFFF -> hi=32'hFFFFFFFE, lo=32'h00000001.
REQ-030 div: rs=32'hFFFFFFF9 (-7), rt=2 -> lo=32'hFFFFFFFD, hi=32'hFFFFFFFF, div0=0.
REQ-031 divu: rs=100, rt=0 -> lo=32'hFFFFFFFF, hi=100, div0=1; then divu 100/7 -> lo=14, hi=2, div0=0.
REQ-032 Pre-load hi=32'h1234 via mthi, start mult, assert flush at cycle 10 -> IDLE next cycle, no done, hi=32'h1234; start pulses and hi_we at cycles 5 and 20 of a later operation are ignored.
REQ-033 Assert reset at cycle 15 of a divu -> next cycle busy=0, hi=lo=0, div0=0, no done pulse.
